// File: rtl/hub75_fb_loader_pkg.sv
// Shared definitions for the HUB75 frame-buffer loader: FSM encoding and line helpers.
package hub75_fb_loader_pkg;

    typedef enum logic [2:0] {
        StFill,
        StRowWait,
        StCommit,
        StFlush,
        StSwap,
        StFwait
    } loader_state_e;

    function automatic logic is_last_line(input int unsigned line, input int unsigned n_lines);
        return line == n_lines - 1;
    endfunction

endpackage

// File: rtl/hub75_fb_loader.sv
// Raster pixel stream to HUB75 frame-buffer writer: fills the line buffer, commits each
// line to its bank/row, then requests a frame swap once the whole frame is stored.
module hub75_fb_loader
    import hub75_fb_loader_pkg::*;
#(
    parameter int unsigned N_BANKS     = 2,
    parameter int unsigned N_ROWS      = 32,
    parameter int unsigned N_COLS      = 64,
    parameter int unsigned BITDEPTH    = 24,
    parameter int unsigned LOG_N_BANKS = (N_BANKS > 1) ? $clog2(N_BANKS) : 1,
    parameter int unsigned LOG_N_ROWS  = $clog2(N_ROWS),
    parameter int unsigned LOG_N_COLS  = $clog2(N_COLS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [BITDEPTH-1:0]    in_data,
    input  logic                   in_sof,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [LOG_N_BANKS-1:0] fbw_bank_addr,
    output logic [LOG_N_ROWS-1:0]  fbw_row_addr,
    output logic                   fbw_row_store,
    input  logic                   fbw_row_rdy,
    output logic                   fbw_row_swap,
    output logic [BITDEPTH-1:0]    fbw_data,
    output logic [LOG_N_COLS-1:0]  fbw_col_addr,
    output logic                   fbw_wren,
    output logic                   frame_swap,
    input  logic                   frame_rdy,
    output logic                   stat_resync
);

    localparam int unsigned LOG_N_LINES = LOG_N_BANKS + LOG_N_ROWS;
    localparam int unsigned N_LINES     = N_BANKS * N_ROWS;
    localparam logic [LOG_N_COLS-1:0] COL_LAST = LOG_N_COLS'(N_COLS - 1);

    loader_state_e            state_q, state_d;
    logic [LOG_N_COLS-1:0]    col_q, col_d;
    logic [LOG_N_LINES-1:0]   line_q, line_d;
    // High in the first cycle of every state; gates the wait states' exit conditions.
    logic                     first_q;

    logic accept;
    logic resync;

    assign in_ready = (state_q == StFill) & ~rst;
    assign accept   = in_valid & in_ready;
    assign resync   = accept & in_sof & ((col_q != '0) | (line_q != '0));

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        line_d  = line_q;
        unique case (state_q)
            StFill: begin
                if (accept) begin
                    if (resync) begin
                        // Restart the frame: this pixel becomes col 0 of line 0.
                        col_d  = LOG_N_COLS'(1);
                        line_d = '0;
                    end else begin
                        col_d = col_q + 1'b1;
                        if (col_q == COL_LAST) begin
                            state_d = StRowWait;
                        end
                    end
                end
            end
            StRowWait: begin
                // The last column write is on the bus during the first cycle.
                if (fbw_row_rdy && !first_q) begin
                    state_d = StCommit;
                end
            end
            StCommit: begin
                if (is_last_line(32'(line_q), N_LINES)) begin
                    line_d  = '0;
                    state_d = StFlush;
                end else begin
                    line_d  = line_q + 1'b1;
                    state_d = StFill;
                end
            end
            StFlush: begin
                if (fbw_row_rdy && !first_q) begin
                    state_d = StSwap;
                end
            end
            StSwap: begin
                state_d = StFwait;
            end
            StFwait: begin
                // The driver's pending flag is registered, so frame_rdy is stale for a cycle.
                if (frame_rdy && !first_q) begin
                    state_d = StFill;
                end
            end
            default: begin
                state_d = StFill;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StFill;
            col_q         <= '0;
            line_q        <= '0;
            first_q       <= 1'b0;
            fbw_wren      <= 1'b0;
            fbw_col_addr  <= '0;
            fbw_data      <= '0;
            fbw_row_store <= 1'b0;
            fbw_row_swap  <= 1'b0;
            fbw_bank_addr <= '0;
            fbw_row_addr  <= '0;
            frame_swap    <= 1'b0;
            stat_resync   <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            line_q        <= line_d;
            first_q       <= (state_d != state_q);
            fbw_wren      <= accept;
            if (accept) begin
                fbw_col_addr <= resync ? '0 : col_q;
                fbw_data     <= in_data;
            end
            stat_resync   <= resync;
            fbw_row_store <= (state_d == StCommit);
            fbw_row_swap  <= (state_d == StCommit);
            frame_swap    <= (state_d == StSwap);
            // Address is latched on entry to COMMIT and held until the next commit.
            if (state_d == StCommit) begin
                {fbw_bank_addr, fbw_row_addr} <= line_q;
            end
        end
    end

endmodule

// File: tb/tb_hub75_fb_loader.sv
// Randomized bench for hub75_fb_loader; a frame-position model predicts writes, commits,
// swaps, resyncs and in_ready.
module tb_hub75_fb_loader;

    localparam int unsigned N_BANKS  = 2;
    localparam int unsigned N_ROWS   = 4;
    localparam int unsigned N_COLS   = 8;
    localparam int unsigned BITDEPTH = 24;
    localparam int unsigned N_LINES  = N_BANKS * N_ROWS;
    localparam int unsigned N_PIX    = N_LINES * N_COLS;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [BITDEPTH-1:0] in_data = '0;
    logic                in_sof = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [0:0]          fbw_bank_addr;
    logic [1:0]          fbw_row_addr;
    logic                fbw_row_store;
    logic                fbw_row_rdy = 1'b1;
    logic                fbw_row_swap;
    logic [BITDEPTH-1:0] fbw_data;
    logic [2:0]          fbw_col_addr;
    logic                fbw_wren;
    logic                frame_swap;
    logic                frame_rdy = 1'b1;
    logic                stat_resync;

    hub75_fb_loader #(
        .N_BANKS (N_BANKS),
        .N_ROWS  (N_ROWS),
        .N_COLS  (N_COLS),
        .BITDEPTH(BITDEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_sof       (in_sof),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .fbw_bank_addr(fbw_bank_addr),
        .fbw_row_addr (fbw_row_addr),
        .fbw_row_store(fbw_row_store),
        .fbw_row_rdy  (fbw_row_rdy),
        .fbw_row_swap (fbw_row_swap),
        .fbw_data     (fbw_data),
        .fbw_col_addr (fbw_col_addr),
        .fbw_wren     (fbw_wren),
        .frame_swap   (frame_swap),
        .frame_rdy    (frame_rdy),
        .stat_resync  (stat_resync)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: absolute position within the frame plus pending events.
    int pos = 0;
    bit blocked = 0;
    bit release_pend = 0;
    int fw_stage = 0;
    bit swap_due = 0;
    int exp_lines[$];
    int last_line = 0;
    int commits_seen = 0;
    int swaps_seen = 0;
    int resync_seen = 0;
    bit prev_store = 0;
    bit prev_swap = 0;
    bit last_acc = 0;
    // Responders emulating the panel driver.
    int row_low_len = 0;
    int rcnt = 0;
    int frame_hold = 0;
    int fcnt = 0;

    function automatic bit model_idle();
        return !blocked && !release_pend && fw_stage == 0 && !swap_due && exp_lines.size() == 0;
    endfunction

    task automatic step();
        bit acc, sof_s, rdy_s, frdy_s, rst_s, exp_rs, exit_fw, adv_fw;
        logic [BITDEPTH-1:0] d_s;
        int exp_col, l;
        #1;
        rst_s   = rst;
        acc     = in_valid && in_ready && !rst_s;
        sof_s   = in_sof;
        d_s     = in_data;
        rdy_s   = fbw_row_rdy;
        frdy_s  = frame_rdy;
        exp_rs  = 0;
        exp_col = 0;
        exit_fw = (fw_stage == 3) && frdy_s;
        adv_fw  = (fw_stage == 1) || (fw_stage == 2);
        if (rst_s) begin
            pos = 0; blocked = 0; release_pend = 0; fw_stage = 0; swap_due = 0;
            exp_lines.delete(); last_line = 0;
        end else if (acc) begin
            if (sof_s && pos != 0) begin
                exp_rs = 1;
                pos = 0;
            end
            exp_col = pos % N_COLS;
            pos++;
            if (pos % N_COLS == 0) begin
                blocked = 1;
                exp_lines.push_back(pos / N_COLS - 1);
                if (pos == N_PIX) begin
                    pos = 0;
                    swap_due = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        if (rst_s) begin
            check("rst_wren", fbw_wren, 0);
            check("rst_col", fbw_col_addr, 0);
            check("rst_data", fbw_data, 0);
            check("rst_store", {fbw_row_store, fbw_row_swap}, 0);
            check("rst_addr", {fbw_bank_addr, fbw_row_addr}, 0);
            check("rst_fswap", frame_swap, 0);
            check("rst_resync", stat_resync, 0);
            check("rst_ready", in_ready, 0);
            prev_store = 0;
            prev_swap  = 0;
        end else begin
            check("wren", fbw_wren, acc);
            if (acc) begin
                check("col", fbw_col_addr, exp_col);
                check("data", fbw_data, d_s);
            end
            check("resync", stat_resync, exp_rs);
            if (stat_resync) resync_seen++;
            if (release_pend) begin
                blocked = 0;
                release_pend = 0;
            end
            if (exit_fw) begin
                blocked = 0;
                fw_stage = 0;
            end else if (adv_fw) begin
                fw_stage++;
            end
            check("in_ready", in_ready, !blocked);
            if (fbw_row_store) begin
                check("store_rdy", rdy_s, 1);
                check("store_single", prev_store, 0);
                check("store_pending", exp_lines.size() > 0, 1);
                if (exp_lines.size() > 0) begin
                    l = exp_lines.pop_front();
                    check("store_line", {fbw_bank_addr, fbw_row_addr}, l);
                    last_line = l;
                    if (l != N_LINES - 1) release_pend = 1;
                end
                check("row_swap", fbw_row_swap, 1);
                commits_seen++;
            end else begin
                check("row_swap_idle", fbw_row_swap, 0);
            end
            check("addr_hold", {fbw_bank_addr, fbw_row_addr}, last_line);
            if (frame_swap) begin
                check("swap_excl", fbw_row_store, 0);
                check("swap_single", prev_swap, 0);
                check("swap_due", swap_due && exp_lines.size() == 0 && !prev_store, 1);
                swap_due = 0;
                fw_stage = 1;
                swaps_seen++;
            end
            prev_store = fbw_row_store;
            prev_swap  = frame_swap;
        end
        last_acc = acc;
        if (rcnt > 0) begin
            rcnt--;
            if (rcnt == 0) fbw_row_rdy = 1'b1;
        end
        if (fbw_row_store && row_low_len > 0) begin
            fbw_row_rdy = 1'b0;
            rcnt = row_low_len;
        end
        if (!frame_rdy) begin
            if (fcnt == 0) frame_rdy = 1'b1;
            else fcnt--;
        end
        if (frame_swap) begin
            frame_rdy = 1'b0;
            fcnt = frame_hold;
        end
    endtask

    task automatic send_pixel(input logic [BITDEPTH-1:0] d, input bit sof, input int gap);
        int n = 0;
        in_data = d;
        in_sof  = sof;
        forever begin
            in_valid = ($urandom_range(99) >= gap);
            step();
            if (last_acc) break;
            n++;
            if (n > 300) begin
                check("pixel_timeout", last_acc, 1);
                break;
            end
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_frame(input bit rand_data, input bit sof0, input int gap);
        for (int i = 0; i < N_PIX; i++) begin
            send_pixel(rand_data ? BITDEPTH'($urandom) : BITDEPTH'(i), sof0 && i == 0, gap);
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (!model_idle() && n < budget) begin
            step();
            n++;
        end
        check(tag, model_idle(), 1);
    endtask

    int c0, s0, r0;

    initial begin
        // Reset state.
        step();
        step();
        rst = 1'b0;

        // Contiguous frame, data = index, rdy tied high.
        c0 = commits_seen; s0 = swaps_seen;
        send_frame(0, 1, 0);
        wait_idle("t1_idle", 200);
        check("t1_commits", commits_seen - c0, 8);
        check("t1_swaps", swaps_seen - s0, 1);

        // Random gaps, row_rdy low for 10 cycles after each commit.
        row_low_len = 10;
        c0 = commits_seen; s0 = swaps_seen;
        for (int f = 0; f < 2; f++) send_frame(1, 1, 50);
        wait_idle("t2_idle", 400);
        check("t2_commits", commits_seen - c0, 16);
        check("t2_swaps", swaps_seen - s0, 2);
        row_low_len = 0;

        // Back-to-back frames, frame_rdy held low after each swap; second frame has no sof.
        frame_hold = 20;
        c0 = commits_seen; s0 = swaps_seen;
        send_frame(1, 1, 0);
        send_frame(1, 0, 0);
        wait_idle("t3_idle", 400);
        check("t3_commits", commits_seen - c0, 16);
        check("t3_swaps", swaps_seen - s0, 2);
        frame_hold = 0;

        // Resync on pixel 19, then a full frame of 63 more pixels.
        c0 = commits_seen; s0 = swaps_seen; r0 = resync_seen;
        for (int i = 0; i < 19; i++) send_pixel(BITDEPTH'(i), i == 0, 0);
        send_pixel(BITDEPTH'(24'hABCDEF), 1, 0);
        for (int i = 0; i < N_PIX - 1; i++) send_pixel(BITDEPTH'($urandom), 0, 0);
        wait_idle("t4_idle", 200);
        check("t4_resyncs", resync_seen - r0, 1);
        check("t4_commits", commits_seen - c0, 10);
        check("t4_swaps", swaps_seen - s0, 1);

        // Reset while line 5 waits for row_rdy.
        c0 = commits_seen; s0 = swaps_seen;
        for (int i = 0; i < 40; i++) send_pixel(BITDEPTH'($urandom), i == 0, 0);
        wait_idle("t5_line4", 50);
        fbw_row_rdy = 1'b0;
        for (int i = 0; i < 8; i++) send_pixel(BITDEPTH'($urandom), 0, 0);
        for (int i = 0; i < 3; i++) step();
        check("t5_blocked", blocked, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        fbw_row_rdy = 1'b1;
        for (int i = 0; i < 4; i++) step();
        send_frame(1, 0, 0);
        wait_idle("t5_idle", 200);
        check("t5_commits", commits_seen - c0, 13);
        check("t5_swaps", swaps_seen - s0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
